// File: rtl/borsa_coklu_karar.sv
// Multi-channel stock buy decision: one restoring divide per channel, picks the largest share
// count, and emits an order word. Define BORSA_SIFRELEME_EN to multiply the packet by the key.
module borsa_coklu_karar #(
  parameter int unsigned HISSE_SAYISI = 4,
  parameter int unsigned ESIK         = 1000,
  parameter int unsigned KW           = $clog2(HISSE_SAYISI + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       basla,
  input  logic [36:0]                yatirimci_kimlikno,
  input  logic [10*HISSE_SAYISI-1:0] hisse_numaralari,
  input  logic [32*HISSE_SAYISI-1:0] hisse_degerleri,
  input  logic [63:0]                bakiye,
  output logic                       mesgul,
  output logic                       gecerli,
  output logic [KW-1:0]              karar,
  output logic [63:0]                kagit_sayisi,
  output logic [63:0]                sifre_cikisi,
  output logic [15:0]                sifre_anahtari
);

  localparam int unsigned KI = $clog2(HISSE_SAYISI);

  typedef enum logic [2:0] {StBosta, StBol, StKarsilastir, StSifrele, StBitti} durum_e;

  durum_e        durum_q, durum_d;
  logic [KI-1:0] kanal_q, kanal_d;
  logic [5:0]    sayac_q, sayac_d;
  logic [31:0]   kalan_q, kalan_d;
  logic [63:0]   bolum_q, bolum_d;
  logic [63:0]   best_q, best_d;
  logic [KI-1:0] best_i_q, best_i_d;
  logic [36:0]   kimlik_q, kimlik_d;
  logic [63:0]   bakiye_q, bakiye_d;
  logic [9:0]    numara_q [HISSE_SAYISI];
  logic [9:0]    numara_d [HISSE_SAYISI];
  logic [31:0]   deger_q [HISSE_SAYISI];
  logic [31:0]   deger_d [HISSE_SAYISI];
  logic [63:0]   paket_q, paket_d;
  logic [KW-1:0] karar_q, karar_d;
  logic [63:0]   kagit_q, kagit_d;
  logic [63:0]   sifre_q, sifre_d;
  logic [15:0]   anahtar_q, anahtar_d;

  logic [31:0]   bolen;
  logic [32:0]   kaydir;
  logic          buyuk_esit;
  logic [63:0]   aday;
  logic [KW-1:0] karar_sec;
  logic [9:0]    secilen_no;

  assign bolen      = deger_q[kanal_q];
  assign kaydir     = {kalan_q, bolum_q[63]};
  assign buyuk_esit = kaydir >= {1'b0, bolen};
  // A zero price would yield all-ones; treat it as "cannot buy".
  assign aday       = (bolen == '0) ? '0 : bolum_q;
  assign karar_sec  = (best_q > 64'(ESIK)) ? KW'(best_i_q) + KW'(1) : '0;
  assign secilen_no = (karar_sec != '0) ? numara_q[best_i_q] : '0;

`ifdef BORSA_SIFRELEME_EN
  logic [15:0] anahtar_hesap;
  always_comb begin
    anahtar_hesap = '0;
    for (int i = 0; i < int'(HISSE_SAYISI) - 1; i++) begin
      anahtar_hesap = anahtar_hesap ^ {6'b0, numara_q[i]};
    end
    anahtar_hesap = (anahtar_hesap << 6) + {6'b0, numara_q[HISSE_SAYISI-1]};
  end
`endif

  always_comb begin
    durum_d   = durum_q;
    kanal_d   = kanal_q;
    sayac_d   = sayac_q;
    kalan_d   = kalan_q;
    bolum_d   = bolum_q;
    best_d    = best_q;
    best_i_d  = best_i_q;
    kimlik_d  = kimlik_q;
    bakiye_d  = bakiye_q;
    numara_d  = numara_q;
    deger_d   = deger_q;
    paket_d   = paket_q;
    karar_d   = karar_q;
    kagit_d   = kagit_q;
    sifre_d   = sifre_q;
    anahtar_d = anahtar_q;
    case (durum_q)
      StBosta: begin
        if (basla) begin
          kimlik_d = yatirimci_kimlikno;
          bakiye_d = bakiye;
          for (int i = 0; i < int'(HISSE_SAYISI); i++) begin
            numara_d[i] = hisse_numaralari[10*i +: 10];
            deger_d[i]  = hisse_degerleri[32*i +: 32];
          end
          kanal_d  = '0;
          sayac_d  = '0;
          kalan_d  = '0;
          bolum_d  = bakiye;
          best_d   = '0;
          best_i_d = '0;
          durum_d  = StBol;
        end
      end
      StBol: begin
        kalan_d = buyuk_esit ? 32'(kaydir - {1'b0, bolen}) : kaydir[31:0];
        bolum_d = {bolum_q[62:0], buyuk_esit};
        sayac_d = sayac_q + 6'd1;
        if (sayac_q == 6'd63) durum_d = StKarsilastir;
      end
      StKarsilastir: begin
        if (aday > best_q) begin
          best_d   = aday;
          best_i_d = kanal_q;
        end
        if (kanal_q == KI'(HISSE_SAYISI - 1)) begin
          durum_d = StSifrele;
        end else begin
          kanal_d = kanal_q + KI'(1);
          kalan_d = '0;
          bolum_d = bakiye_q;
          durum_d = StBol;
        end
      end
      StSifrele: begin
        // Two phases: register the packet, then form the product into the outputs.
        if (!sayac_q[0]) begin
          paket_d = {17'b0, kimlik_q, secilen_no};
          sayac_d = 6'd1;
        end else begin
          sayac_d = '0;
          karar_d = karar_sec;
          kagit_d = (karar_sec != '0) ? best_q : '0;
`ifdef BORSA_SIFRELEME_EN
          sifre_d   = paket_q * {48'b0, anahtar_hesap};
          anahtar_d = anahtar_hesap;
`else
          sifre_d   = paket_q;
          anahtar_d = '0;
`endif
          durum_d = StBitti;
        end
      end
      StBitti: durum_d = StBosta;
      default: durum_d = StBosta;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q   <= StBosta;
      kanal_q   <= '0;
      sayac_q   <= '0;
      kalan_q   <= '0;
      bolum_q   <= '0;
      best_q    <= '0;
      best_i_q  <= '0;
      kimlik_q  <= '0;
      bakiye_q  <= '0;
      numara_q  <= '{default: '0};
      deger_q   <= '{default: '0};
      paket_q   <= '0;
      karar_q   <= '0;
      kagit_q   <= '0;
      sifre_q   <= '0;
      anahtar_q <= '0;
    end else begin
      durum_q   <= durum_d;
      kanal_q   <= kanal_d;
      sayac_q   <= sayac_d;
      kalan_q   <= kalan_d;
      bolum_q   <= bolum_d;
      best_q    <= best_d;
      best_i_q  <= best_i_d;
      kimlik_q  <= kimlik_d;
      bakiye_q  <= bakiye_d;
      numara_q  <= numara_d;
      deger_q   <= deger_d;
      paket_q   <= paket_d;
      karar_q   <= karar_d;
      kagit_q   <= kagit_d;
      sifre_q   <= sifre_d;
      anahtar_q <= anahtar_d;
    end
  end

  assign mesgul         = (durum_q != StBosta);
  assign gecerli        = (durum_q == StBitti);
  assign karar          = karar_q;
  assign kagit_sayisi   = kagit_q;
  assign sifre_cikisi   = sifre_q;
  assign sifre_anahtari = anahtar_q;

endmodule

// File: tb/tb_borsa_coklu_karar.sv
// Randomized and directed bench for borsa_coklu_karar against a division-based reference model.
module tb_borsa_coklu_karar;

  localparam int N    = 4;
  localparam int ESIK = 1000;
  localparam int KW   = $clog2(N + 1);
  localparam int LAT  = N * 65 + 2;

  logic            clk;
  logic            rst_n;
  logic            basla;
  logic [36:0]     yatirimci_kimlikno;
  logic [10*N-1:0] hisse_numaralari;
  logic [32*N-1:0] hisse_degerleri;
  logic [63:0]     bakiye;
  logic            mesgul;
  logic            gecerli;
  logic [KW-1:0]   karar;
  logic [63:0]     kagit_sayisi;
  logic [63:0]     sifre_cikisi;
  logic [15:0]     sifre_anahtari;

  borsa_coklu_karar #(
    .HISSE_SAYISI(N),
    .ESIK        (ESIK)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .basla             (basla),
    .yatirimci_kimlikno(yatirimci_kimlikno),
    .hisse_numaralari  (hisse_numaralari),
    .hisse_degerleri   (hisse_degerleri),
    .bakiye            (bakiye),
    .mesgul            (mesgul),
    .gecerli           (gecerli),
    .karar             (karar),
    .kagit_sayisi      (kagit_sayisi),
    .sifre_cikisi      (sifre_cikisi),
    .sifre_anahtari    (sifre_anahtari)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Job stimulus
  logic [31:0] pr [N];
  logic [9:0]  nm [N];
  logic [63:0] bak;
  logic [36:0] kim;

  // Expected (held) output values
  logic [63:0] e_karar = '0;
  logic [63:0] e_kagit = '0;
  logic [63:0] e_sifre = '0;
  logic [63:0] e_key   = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compute_expected();
    logic [63:0] q, best, p;
    logic [15:0] x;
    logic [9:0]  no;
    int          bi;
    best = '0;
    bi   = 0;
    for (int i = 0; i < N; i++) begin
      q = (pr[i] == 0) ? 64'd0 : bak / {32'b0, pr[i]};
      if (q > best) begin
        best = q;
        bi   = i;
      end
    end
    if (best > 64'(ESIK)) begin
      e_karar = 64'(bi + 1);
      e_kagit = best;
      no      = nm[bi];
    end else begin
      e_karar = '0;
      e_kagit = '0;
      no      = '0;
    end
    p = {17'b0, kim, no};
    x = '0;
    for (int i = 0; i < N - 1; i++) x = x ^ {6'b0, nm[i]};
    x = (x << 6) + {6'b0, nm[N-1]};
`ifdef BORSA_SIFRELEME_EN
    e_sifre = p * {48'b0, x};
    e_key   = {48'b0, x};
`else
    e_sifre = p;
    e_key   = '0;
`endif
  endtask

  task automatic drive_job();
    bak                = bak;
    bakiye             = bak;
    yatirimci_kimlikno = kim;
    for (int i = 0; i < N; i++) begin
      hisse_numaralari[10*i +: 10] = nm[i];
      hisse_degerleri[32*i +: 32]  = pr[i];
    end
    basla = 1'b1;
  endtask

  task automatic scramble_inputs();
    bakiye             = {$urandom, $urandom};
    yatirimci_kimlikno = {5'($urandom), $urandom};
    for (int i = 0; i < N; i++) begin
      hisse_numaralari[10*i +: 10] = 10'($urandom);
      hisse_degerleri[32*i +: 32]  = $urandom_range(1, 50);
    end
  endtask

  // Caller must be at a falling edge; the job is accepted on the next rising edge.
  task automatic run_job(input string name);
    logic [63:0] o_karar, o_kagit, o_sifre;
    int cyc;
    bit seen;
    o_karar = e_karar;
    o_kagit = e_kagit;
    o_sifre = e_sifre;
    drive_job();
    @(posedge clk);
    #1;
    check_eq({name, ".mesgul_on"}, 64'(mesgul), 64'd1);
    compute_expected();
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      if (cyc == 0) begin
        basla = 1'b0;
        scramble_inputs();
      end
      if (cyc == 40) basla = 1'b1;
      if (cyc == 41) basla = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      if (gecerli) seen = 1;
      else if (cyc == 100) begin
        check_eq({name, ".held_karar"}, 64'(karar), o_karar);
        check_eq({name, ".held_kagit"}, kagit_sayisi, o_kagit);
        check_eq({name, ".held_sifre"}, sifre_cikisi, o_sifre);
      end
    end
    check_eq({name, ".latency"}, 64'(cyc), 64'(LAT));
    check_eq({name, ".karar"}, 64'(karar), e_karar);
    check_eq({name, ".kagit"}, kagit_sayisi, e_kagit);
    check_eq({name, ".sifre"}, sifre_cikisi, e_sifre);
    check_eq({name, ".anahtar"}, 64'(sifre_anahtari), e_key);
    check_eq({name, ".mesgul_in_valid"}, 64'(mesgul), 64'd1);
    @(posedge clk);
    #1;
    check_eq({name, ".pulse_end"}, 64'(gecerli), 64'd0);
    check_eq({name, ".mesgul_off"}, 64'(mesgul), 64'd0);
    check_eq({name, ".karar_held"}, 64'(karar), e_karar);
  endtask

  task automatic set_prices(input int a, input int b, input int c, input int d);
    pr[0] = 32'(a);
    pr[1] = 32'(b);
    pr[2] = 32'(c);
    pr[3] = 32'(d);
  endtask

  initial begin
    int g_count;
    rst_n = 1'b0;
    basla = 1'b0;
    bakiye = '0;
    yatirimci_kimlikno = '0;
    hisse_numaralari = '0;
    hisse_degerleri = '0;
    for (int i = 0; i < N; i++) nm[i] = 10'(i + 1);
    kim = 37'd5;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.mesgul", 64'(mesgul), 64'd0);
    check_eq("rst.gecerli", 64'(gecerli), 64'd0);
    check_eq("rst.karar", 64'(karar), 64'd0);
    check_eq("rst.kagit", kagit_sayisi, 64'd0);
    check_eq("rst.sifre", sifre_cikisi, 64'd0);
    check_eq("rst.anahtar", 64'(sifre_anahtari), 64'd0);

    // Released and started on the same falling edge: accepted on the first rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    bak = 64'd100000;
    set_prices(100, 50, 200, 400);
    run_job("buy_ch2");

    @(negedge clk);
    bak = 64'd50000;
    set_prices(100, 200, 400, 800);
    run_job("below_esik");

    @(negedge clk);
    bak = 64'd100000;
    set_prices(0, 0, 50, 50);
    run_job("zero_tie");

    @(negedge clk);
    bak = 64'd100000;
    set_prices(100, 100, 100, 50);
    run_job("cipher_ch4");

    @(negedge clk);
    bak = 64'd100000;
    set_prices(100, 100, 100, 100);
    run_job("eq_esik");

    @(negedge clk);
    bak = 64'd100100;
    set_prices(100, 100, 100, 100);
    run_job("esik_plus1");

    // Reset in the middle of a job
    @(negedge clk);
    bak = 64'd100000;
    set_prices(100, 50, 200, 400);
    drive_job();
    @(posedge clk);
    @(negedge clk);
    basla = 1'b0;
    repeat (98) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort.mesgul", 64'(mesgul), 64'd0);
    check_eq("abort.karar", 64'(karar), 64'd0);
    check_eq("abort.kagit", kagit_sayisi, 64'd0);
    check_eq("abort.sifre", sifre_cikisi, 64'd0);
    e_karar = '0;
    e_kagit = '0;
    e_sifre = '0;
    e_key   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g_count = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (gecerli || mesgul) g_count++;
    end
    check_eq("abort.no_activity", 64'(g_count), 64'd0);

    @(negedge clk);
    run_job("after_abort");

    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 7);
        pr[i] = (r == 0) ? 32'd0 : $urandom_range(1, (r < 4) ? 200 : 100000);
        nm[i] = 10'($urandom);
      end
      bak = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 400000));
      kim = {5'($urandom), $urandom};
      @(negedge clk);
      run_job($sformatf("rand%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
